// File: rtl/alu_accum_pkg.sv
// Shared op-code and FSM-state definitions for the accumulator ALU.
package alu_accum_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_LOAD = 3'b111;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

endpackage

// File: rtl/alu_accum_if.sv
// Request/result bundle between the board datapath and the accumulator ALU.
interface alu_accum_if #(
  parameter int WIDTH = 4
) ();
  localparam int ACC_W = 2 * WIDTH;

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [ACC_W-1:0] acc;
  logic             carry;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a,
    input  acc, carry, zero, busy, done
  );

  modport slave (
    input  start, op, a,
    output acc, carry, zero, busy, done
  );
endinterface

// File: rtl/alu_accum_seq_multiplier.sv
// WIDTH-iteration shift-add multiplier; product is the value after the
// iteration currently in flight, so the caller can capture it on the last edge.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);
  localparam int ACC_W = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [ACC_W-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [ACC_W-1:0] r_prod;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  assign busy    = r_busy;
  assign last    = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
  assign product = r_prod + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (load) begin
      r_mcand  <= ACC_W'(a);
      r_mplier <= b;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_prod   <= product;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= last ? '0 : r_cnt + CNT_W'(1);
      r_busy   <= !last;
    end
  end

endmodule

// File: rtl/alu_accum.sv
// Accumulator ALU: single-cycle ops against acc[WIDTH-1:0], sequential multiply,
// start/busy/done handshake.
module alu_accum
  import alu_accum_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic        clk,
  input logic        resetn,
  alu_accum_if.slave bus
);
  localparam int ACC_W = 2 * WIDTH;

  state_t           r_state;
  state_t           w_state_next;
  logic [ACC_W-1:0] r_acc;
  logic             r_carry;
  logic             r_zero;
  logic             r_done;

  logic [ACC_W-1:0] w_acc_next;
  logic             w_carry_next;
  logic             w_done_next;
  logic             w_mul_load;

  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [ACC_W-1:0] w_shl;
  logic [ACC_W-1:0] w_alu_res;
  logic             w_alu_carry;

  logic             w_mul_busy;
  logic             w_mul_last;
  logic [ACC_W-1:0] w_mul_product;

  assign w_b    = r_acc[WIDTH-1:0];
  assign w_sum  = {1'b0, bus.a} + {1'b0, w_b};
  assign w_diff = {1'b0, bus.a} - {1'b0, w_b};
  // Shift amounts at or beyond the accumulator width flush to zero.
  assign w_shl  = (32'(w_b) >= ACC_W) ? '0 : (ACC_W'(bus.a) << w_b);

  always_comb begin
    w_alu_res   = r_acc;
    w_alu_carry = 1'b0;
    unique case (bus.op)
      OP_HOLD: begin
        w_alu_res   = r_acc;
        w_alu_carry = r_carry;
      end
      OP_ADD: begin
        w_alu_res   = ACC_W'(w_sum);
        w_alu_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_alu_res   = ACC_W'(w_diff[WIDTH-1:0]);
        w_alu_carry = w_diff[WIDTH];
      end
      OP_AND:  w_alu_res = ACC_W'(bus.a & w_b);
      OP_OR:   w_alu_res = ACC_W'(bus.a | w_b);
      OP_SHL:  w_alu_res = w_shl;
      OP_MUL:  w_alu_res = r_acc;
      OP_LOAD: w_alu_res = ACC_W'(bus.a);
    endcase
  end

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .resetn  (resetn),
    .load    (w_mul_load),
    .a       (bus.a),
    .b       (w_b),
    .busy    (w_mul_busy),
    .last    (w_mul_last),
    .product (w_mul_product)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_carry_next = r_carry;
    w_done_next  = 1'b0;
    w_mul_load   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            w_mul_load   = 1'b1;
            w_state_next = MUL_RUN;
          end else begin
            w_acc_next   = w_alu_res;
            w_carry_next = w_alu_carry;
            w_done_next  = 1'b1;
          end
        end
      end
      MUL_RUN: begin
        // Requests arriving here are dropped, not queued.
        if (w_mul_last) begin
          w_acc_next   = w_mul_product;
          w_carry_next = 1'b0;
          w_done_next  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_acc   <= w_acc_next;
      r_carry <= w_carry_next;
      r_zero  <= (w_acc_next == '0);
      r_done  <= w_done_next;
    end
  end

  assign bus.acc   = r_acc;
  assign bus.carry = r_carry;
  assign bus.zero  = r_zero;
  assign bus.busy  = w_mul_busy;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_alu_accum.sv
// Bench for alu_accum (WIDTH=4): vector table through a done-driven scoreboard,
// plus hand sequences for multiply, dropped requests and reset mid-multiply.
module tb_alu_accum;
  import alu_accum_pkg::*;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [7:0] acc;
    logic       carry;
    logic       zero;
  } vec_t;

  typedef struct {
    logic [7:0] acc;
    logic       carry;
    logic       zero;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;
  exp_t q[$];
  vec_t vecs[22];

  alu_accum_if #(.WIDTH(4)) bus ();

  alu_accum #(.WIDTH(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] a,
                       input logic push, input exp_t e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    if (push) q.push_back(e);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && bus.done) begin
      if (q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL done_unexpected: got done=1 with acc=0x%0h expected no done", bus.acc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result{acc,carry,zero}", {22'd0, bus.acc, bus.carry, bus.zero},
              {22'd0, e.acc, e.carry, e.zero});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   nbusy;
    bus.start = 1'b0;
    bus.op    = OP_HOLD;
    bus.a     = '0;

    vecs[0]  = '{OP_LOAD, 4'h9, 8'h09, 1'b0, 1'b0};
    vecs[1]  = '{OP_ADD,  4'h9, 8'h12, 1'b1, 1'b0};
    vecs[2]  = '{OP_LOAD, 4'h3, 8'h03, 1'b0, 1'b0};
    vecs[3]  = '{OP_SUB,  4'h1, 8'h0E, 1'b1, 1'b0};
    vecs[4]  = '{OP_AND,  4'h1, 8'h00, 1'b0, 1'b1};
    vecs[5]  = '{OP_HOLD, 4'h0, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{OP_LOAD, 4'h2, 8'h02, 1'b0, 1'b0};
    vecs[7]  = '{OP_SHL,  4'hB, 8'h2C, 1'b0, 1'b0};
    vecs[8]  = '{OP_LOAD, 4'h9, 8'h09, 1'b0, 1'b0};
    vecs[9]  = '{OP_SHL,  4'h1, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{OP_LOAD, 4'h5, 8'h05, 1'b0, 1'b0};
    vecs[11] = '{OP_OR,   4'hA, 8'h0F, 1'b0, 1'b0};
    vecs[12] = '{OP_ADD,  4'h1, 8'h10, 1'b1, 1'b0};
    vecs[13] = '{OP_HOLD, 4'h3, 8'h10, 1'b1, 1'b0};
    vecs[14] = '{OP_SUB,  4'h7, 8'h07, 1'b0, 1'b0};
    vecs[15] = '{OP_SUB,  4'h7, 8'h00, 1'b0, 1'b1};
    vecs[16] = '{OP_LOAD, 4'h0, 8'h00, 1'b0, 1'b1};
    vecs[17] = '{OP_SHL,  4'h3, 8'h03, 1'b0, 1'b0};
    vecs[18] = '{OP_SHL,  4'h1, 8'h08, 1'b0, 1'b0};
    vecs[19] = '{OP_SHL,  4'h1, 8'h00, 1'b0, 1'b1};
    vecs[20] = '{OP_LOAD, 4'h7, 8'h07, 1'b0, 1'b0};
    vecs[21] = '{OP_SHL,  4'h1, 8'h80, 1'b0, 1'b0};

    // Reset state, then idle with start low.
    #12;
    check("reset_acc", 32'(bus.acc), 32'h00);
    check("reset_carry", 32'(bus.carry), 32'h0);
    check("reset_zero", 32'(bus.zero), 32'h1);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_acc", 32'(bus.acc), 32'h00);
    check("idle_zero", 32'(bus.zero), 32'h1);
    check("idle_done", 32'(bus.done), 32'h0);

    // Back-to-back single-cycle ops.
    for (int i = 0; i < 22; i++) begin
      e = '{vecs[i].acc, vecs[i].carry, vecs[i].zero};
      issue(vecs[i].op, vecs[i].a, 1'b1, e);
    end
    issue(OP_ADD, 4'hF, 1'b1, '{8'h0F, 1'b0, 1'b0});

    // 15*15 multiply with a LOAD request arriving mid-run.
    issue(OP_LOAD, 4'hF, 1'b1, '{8'h0F, 1'b0, 1'b0});
    issue(OP_MUL, 4'hF, 1'b1, '{8'hE1, 1'b0, 1'b0});
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      nbusy++;
      if (nbusy == 1) begin
        bus.start = 1'b1;
        bus.op    = OP_LOAD;
        bus.a     = 4'h5;
      end
      if (nbusy == 2) begin
        bus.start = 1'b0;
        check("mul_acc_held", 32'(bus.acc), 32'h0F);
      end
    end
    check("mul_busy_cycles", 32'(nbusy), 32'd4);
    check("mul_done_edge", 32'(bus.done), 32'h1);
    repeat (3) @(negedge clk);
    check("mul_acc_after_drop", 32'(bus.acc), 32'hE1);
    check("mul_queue_drained", 32'(q.size()), 32'd0);

    // Reset asserted during the second busy cycle abandons the multiply.
    issue(OP_LOAD, 4'h3, 1'b1, '{8'h03, 1'b0, 1'b0});
    issue(OP_MUL, 4'h7, 1'b0, e);
    @(negedge clk);
    check("rst_mul_busy1", 32'(bus.busy), 32'h1);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("rst_mul_acc", 32'(bus.acc), 32'h00);
    check("rst_mul_busy", 32'(bus.busy), 32'h0);
    check("rst_mul_zero", 32'(bus.zero), 32'h1);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_mul_acc_after", 32'(bus.acc), 32'h00);
    check("rst_mul_busy_after", 32'(bus.busy), 32'h0);
    check("final_queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_accum.md
# alu_accum

Parametrised accumulator ALU for the lab-board datapath. It is the successor of the 4-bit switch/register ALU. It combines a WIDTH-bit input operand with the low half of a 2·WIDTH-bit accumulator register, under a start/busy/done handshake. Add, subtract, bitwise, shift and load complete in one cycle. Multiply is a multi-cycle sequential shift-add. The accumulator and flags drive the board's hex displays and LEDs upstream.

## Interface
- WIDTH, default 4: operand width. The accumulator is 2·WIDTH (derived localparam ACC_W). Legal range is WIDTH ≥ 2.
- clk  in  1  rising-edge clock; the sole clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on clk rising edge.
- op  in  3  operation code (see Operation); sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- acc  out  ACC_W  accumulator register; reset 0.
- carry  out  1  carry/borrow flag, registered; reset 0.
- zero  out  1  registered, equals (acc == 0) after every update; reset 1.
- busy  out  1  high while a multiply is in progress; reset 0.
- done  out  1  one-cycle completion pulse, registered; reset 0.

## Operation
- B = acc[WIDTH-1:0]. Every result is zero-extended to ACC_W.
- Op codes:
  - 000 HOLD: acc unchanged; carry unchanged.
  - 001 ADD: acc = A+B as a WIDTH+1-bit value; carry = bit WIDTH of the sum.
  - 010 SUB: acc = (A−B) mod 2^WIDTH; carry = borrow, i.e. 1 when A<B.
  - 011 AND: acc = A&B; carry = 0.
  - 100 OR: acc = A|B; carry = 0.
  - 101 SHL: acc = (A << B) truncated to ACC_W. If B ≥ ACC_W, acc = 0. carry = 0.
  - 110 MUL: acc = A·B, full ACC_W product; carry = 0.
  - 111 LOAD: acc = A; carry = 0.
- State machine:
  - IDLE: start=1 with a non-MUL op updates acc, carry and zero on that edge, sets done=1 for the next cycle, and stays in IDLE. start=1 with op=MUL latches A and B, clears the internal product and iteration counter, sets busy=1, and moves to MUL_RUN.
  - MUL_RUN: each edge performs one shift-add iteration (multiplier LSB adds the shifted multiplicand). The edge that completes iteration WIDTH writes the product to acc, updates zero, clears carry, sets busy=0 and done=1, and returns to IDLE.
- While in MUL_RUN, start is ignored. Such requests are dropped, not queued, and acc is unchanged until completion.
- done is high for exactly one cycle per accepted request, including HOLD.
- The counter is $clog2(WIDTH+1) bits and wraps to 0 on return to IDLE.

## Timing
- Single-cycle ops: acc, carry and zero are visible in the cycle after the start edge; done is high in that same cycle.
- MUL: busy is high for WIDTH cycles, starting the cycle after the start edge. acc updates and done is high in the cycle after the last busy cycle. Latency from start edge to acc valid is WIDTH+1 edges.
- Back-to-back start in IDLE is accepted every cycle. B always uses the acc value present at the sampling edge.
- resetn low acts immediately, independent of clk. All outputs go to their reset values and any multiply in progress is abandoned without a done pulse. The first start is sampled on the first rising edge after resetn deasserts.

## Structure
- Shared package alu_accum_pkg holds the op-code localparams (OP_HOLD … OP_LOAD) and the IDLE/MUL_RUN state encoding.
- Sub-module seq_multiplier contains the WIDTH-iteration shift-add datapath plus its counter. Its interface is clk, resetn, load, a, b, busy, last, product.
- The top level holds the single-cycle result mux, the accumulator/flag registers and the FSM.

## Test plan
All scenarios use WIDTH=4.
- Reset: hold resetn=0 → acc=0x00, carry=0, zero=1, busy=0, done=0. Then hold start=0 for 3 cycles → outputs unchanged.
- LOAD a=9, then ADD a=9 → acc=0x12, carry=1, zero=0. done pulses once per op.
- LOAD a=3, then SUB a=1 → acc=0x0E, carry=1. Then AND a=0x1 → acc=0x00, zero=1, carry=0.
- LOAD a=2, SHL a=0xB → acc=0x2C. Then LOAD a=9, SHL a=1 → acc=0x00, zero=1.
- LOAD a=0xF, MUL a=0xF → busy high for 4 cycles, then acc=0xE1 with a single done pulse. A start with LOAD a=5 during busy is ignored, so acc is still 0xE1 afterwards.
- MUL started from acc=0x03, a=0x7, with resetn pulsed low in the second busy cycle → acc=0x00 and busy=0 immediately, and no done pulse follows.
